uart_rx_buffer: RTL and testbench

- Sits directly downstream of the UART receiver.
- Watches the receiver's ready/data_out pair, captures each received word into a FWFT FIFO, and pulses the receiver's ready_clr to re-arm it.
- Gives the user logic a valid/pop read interface plus fill-level and overflow status, so received words are not lost while the consumer is busy.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_buffer_if.sv | 43 ++++
 rtl/sync_fifo_fwft.sv | 72 +++++++
 rtl/uart_rx_buffer.sv | 108 ++++++++++
 tb/tb_uart_rx_buffer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default word width, default buffer depth and the
// receive-capture FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_W     = 4;
    localparam int UART_FIFO_DEPTH = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CLR  = 1'b1
    } rx_cap_state_t;

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receiver-side and consumer-side signals of uart_rx_buffer.
// almost_full exists only when UART_RX_BUF_WATERMARK_EN is defined.
interface uart_rx_buffer_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int DEPTH      = UART_FIFO_DEPTH
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_ready_clr;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  pop;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  overflow;
    logic                  overflow_clr;
`ifdef UART_RX_BUF_WATERMARK_EN
    logic                  almost_full;
`endif

    // master: receiver + consumer side; slave: the buffer itself
    modport master (
        output rx_ready, rx_data, pop, overflow_clr,
        input  rx_ready_clr, dout, dout_valid, count, full, overflow
`ifdef UART_RX_BUF_WATERMARK_EN
        , input almost_full
`endif
    );

    modport slave (
        input  rx_ready, rx_data, pop, overflow_clr,
        output rx_ready_clr, dout, dout_valid, count, full, overflow
`ifdef UART_RX_BUF_WATERMARK_EN
        , output almost_full
`endif
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; dout is the storage head, read
// combinationally. Pushes while full are accepted only alongside a real pop.
module sync_fifo_fwft
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int DEPTH      = UART_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      din,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_fwft: DEPTH must be a power of two >= 2");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  wr_en, rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop on an empty FIFO is ignored even if a push lands that cycle.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// Buffers UART receiver words in a FWFT FIFO and re-arms the receiver via
// rx_ready_clr. Optional almost_full output: define UART_RX_BUF_WATERMARK_EN.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int DEPTH      = UART_FIFO_DEPTH,
    parameter int WATERMARK  = 6
) (
    input  logic             clk,
    input  logic             rst,
    uart_rx_buffer_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    if (WATERMARK < 1 || WATERMARK > DEPTH) begin : g_bad_watermark
        $error("uart_rx_buffer: WATERMARK must lie in 1..DEPTH");
    end

    rx_cap_state_t         state_q, state_d;
    logic                  push;
    logic                  rx_ready_clr;
    logic                  drop;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    // One push per receiver word: capture on entry to CLR, then wait for
    // the receiver to drop ready before accepting another word.
    always_comb begin
        state_d      = state_q;
        push         = 1'b0;
        rx_ready_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_ready) begin
                    push    = 1'b1;
                    state_d = CLR;
                end
            end
            CLR: begin
                rx_ready_clr = 1'b1;
                if (!bus.rx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (bus.pop),
        .din   (bus.rx_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A new drop outranks a clear arriving in the same cycle.
    assign drop = push && fifo_full && !bus.pop;

    always_comb begin
        overflow_d = overflow_q;
        if (bus.overflow_clr) overflow_d = 1'b0;
        if (drop)             overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= overflow_d;
    end

`ifdef UART_RX_BUF_WATERMARK_EN
    logic almost_full_q, almost_full_d;

    always_comb begin
        almost_full_d = (int'(fifo_count) >= WATERMARK);
    end

    always_ff @(posedge clk) begin
        if (rst) almost_full_q <= 1'b0;
        else     almost_full_q <= almost_full_d;
    end

    assign bus.almost_full = almost_full_q;
`endif

    assign bus.rx_ready_clr = rx_ready_clr;
    assign bus.dout         = fifo_dout;
    assign bus.dout_valid   = !fifo_empty;
    assign bus.count        = fifo_count;
    assign bus.full         = fifo_full;
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: stimulus queues expected words, a
// negedge monitor checks dout on every accepted pop.
module tb_uart_rx_buffer;

    logic clk;
    logic rst;

    uart_rx_buffer_if #(.DATA_WIDTH(4), .DEPTH(8)) bus ();

    uart_rx_buffer #(
        .DATA_WIDTH (4),
        .DEPTH      (8),
        .WATERMARK  (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    logic [3:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor: every accepted pop must present the oldest expected word.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.pop === 1'b1 && bus.dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: got dout %0d expected no pop", bus.dout);
            end else begin
                logic [3:0] e;
                e = sb.pop_front();
                chk("dout_order", int'(bus.dout), int'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst              = 1'b1;
        bus.rx_ready     = 1'b0;
        bus.rx_data      = '0;
        bus.pop          = 1'b0;
        bus.overflow_clr = 1'b0;
        repeat (cycles) step();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic send_word(input logic [3:0] d, input bit accept);
        bus.rx_data  = d;
        bus.rx_ready = 1'b1;
        if (accept) sb.push_back(d);
        step();
        bus.rx_ready = 1'b0;
        step();
    endtask

    task automatic pop_n(input int n);
        bus.pop = 1'b1;
        repeat (n) step();
        bus.pop = 1'b0;
    endtask

    initial begin
        int max_cnt;

        // Reset then idle
        do_reset(3);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_valid", int'(bus.dout_valid), 0);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        chk("rst_clr", int'(bus.rx_ready_clr), 0);
`ifdef UART_RX_BUF_WATERMARK_EN
        chk("rst_af", int'(bus.almost_full), 0);
`endif

        // Single word, receiver holds ready for 4 cycles
        bus.rx_data  = 4'hA;
        bus.rx_ready = 1'b1;
        sb.push_back(4'hA);
        chk("sw_clr_idle", int'(bus.rx_ready_clr), 0);
        step();
        chk("sw_clr_c1", int'(bus.rx_ready_clr), 1);
        chk("sw_count", int'(bus.count), 1);
        chk("sw_valid", int'(bus.dout_valid), 1);
        chk("sw_dout", int'(bus.dout), 10);
        repeat (3) step();
        bus.rx_ready = 1'b0;
        chk("sw_clr_fall", int'(bus.rx_ready_clr), 1);
        chk("sw_one_push", int'(bus.count), 1);
        step();
        chk("sw_clr_off", int'(bus.rx_ready_clr), 0);
        chk("sw_count_hold", int'(bus.count), 1);
        pop_n(1);
        chk("sw_pop_count", int'(bus.count), 0);
        chk("sw_pop_valid", int'(bus.dout_valid), 0);

        // Fill and overflow; the 9th word arrives with overflow_clr (set wins)
        for (int i = 1; i <= 8; i++) begin
            send_word(4'(i), 1'b1);
            if (i == 7) chk("fill_not_full", int'(bus.full), 0);
        end
        chk("fill_full", int'(bus.full), 1);
        chk("fill_count", int'(bus.count), 8);
        chk("fill_ovf0", int'(bus.overflow), 0);
        bus.rx_data      = 4'd9;
        bus.rx_ready     = 1'b1;
        bus.overflow_clr = 1'b1;
        step();
        bus.overflow_clr = 1'b0;
        bus.rx_ready     = 1'b0;
        chk("ovf_set_wins", int'(bus.overflow), 1);
        chk("ovf_count", int'(bus.count), 8);
        step();
        pop_n(8);
        chk("drain_count", int'(bus.count), 0);
        chk("ovf_sticky", int'(bus.overflow), 1);
        bus.overflow_clr = 1'b1;
        step();
        bus.overflow_clr = 1'b0;
        chk("ovf_clr", int'(bus.overflow), 0);

        // Full with simultaneous pop and push
        for (int i = 1; i <= 8; i++) send_word(4'(i), 1'b1);
        bus.rx_data  = 4'd9;
        bus.rx_ready = 1'b1;
        bus.pop      = 1'b1;
        sb.push_back(4'd9);
        step();
        bus.pop      = 1'b0;
        bus.rx_ready = 1'b0;
        chk("fp_count", int'(bus.count), 8);
        chk("fp_full", int'(bus.full), 1);
        chk("fp_no_ovf", int'(bus.overflow), 0);
        step();
        pop_n(8);
        chk("fp_drain", int'(bus.count), 0);

        // Wrap-around with interleaved push/pop
        max_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            bus.rx_data  = 4'(i % 16);
            bus.rx_ready = 1'b1;
            sb.push_back(4'(i % 16));
            step();
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
            bus.rx_ready = 1'b0;
            bus.pop      = 1'b1;
            step();
            bus.pop = 1'b0;
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
        end
        chk("wrap_max_le2", int'(max_cnt <= 2), 1);
        chk("wrap_empty", int'(bus.count), 0);

        // Pop on empty, and push+pop on empty
        bus.pop = 1'b1;
        step();
        chk("pop_empty", int'(bus.count), 0);
        bus.rx_data  = 4'h5;
        bus.rx_ready = 1'b1;
        sb.push_back(4'h5);
        step();
        bus.pop      = 1'b0;
        bus.rx_ready = 1'b0;
        chk("pushpop_empty", int'(bus.count), 1);
        step();
        pop_n(1);

        // Reset mid-transfer discards contents
        send_word(4'h3, 1'b0);
        send_word(4'h4, 1'b0);
        bus.rx_data  = 4'h6;
        bus.rx_ready = 1'b1;
        step();
        do_reset(1);
        chk("mid_rst_count", int'(bus.count), 0);
        chk("mid_rst_valid", int'(bus.dout_valid), 0);
        chk("mid_rst_clr", int'(bus.rx_ready_clr), 0);

`ifdef UART_RX_BUF_WATERMARK_EN
        // Watermark: almost_full lags count by one cycle
        for (int i = 1; i <= 5; i++) send_word(4'(i), 1'b1);
        bus.rx_data  = 4'd6;
        bus.rx_ready = 1'b1;
        sb.push_back(4'd6);
        step();
        chk("wm_count6", int'(bus.count), 6);
        chk("wm_af_lag", int'(bus.almost_full), 0);
        bus.rx_ready = 1'b0;
        step();
        chk("wm_af_set", int'(bus.almost_full), 1);
        pop_n(1);
        chk("wm_af_hold", int'(bus.almost_full), 1);
        step();
        chk("wm_af_clr", int'(bus.almost_full), 0);
        pop_n(5);
`endif

        step();
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
